// File: rtl/scariv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : scariv_pkg
//  Description : Shared types and helpers for the ALU issue queue control.
//  Revision    : 1.0
// ============================================================================
package scariv_pkg;

    localparam int ALU_ENTRY_SIZE = 8;
    localparam int MAX_ENTRY_SIZE = 32;

    typedef logic [$clog2(ALU_ENTRY_SIZE)-1:0] issue_entry_idx_t;
    typedef logic [ALU_ENTRY_SIZE-1:0]         age_row_t;

    // OR-reduction encoder: exact for one-hot inputs, zero for an all-zero vector.
    function automatic int unsigned onehot_to_index(input logic [MAX_ENTRY_SIZE-1:0] oh);
        int unsigned idx;
        idx = 0;
        for (int i = 0; i < MAX_ENTRY_SIZE; i++) begin
            if (oh[i]) begin
                idx = idx | i;
            end
        end
        return idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/scariv_alu_issue_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : scariv_alu_issue_ctrl_if
//  Description : Dispatch / scheduler / issue-stage signals of one ALU queue.
//  Revision    : 1.0
// ============================================================================
interface scariv_alu_issue_ctrl_if #(
    parameter int ENTRY_SIZE = 8
);
    localparam int ENTRY_W = $clog2(ENTRY_SIZE);

    logic                  i_put_valid;
    logic                  o_put_ready;
    logic [ENTRY_SIZE-1:0] o_put_oh;
    logic [ENTRY_W-1:0]    o_put_index;
    logic [ENTRY_SIZE-1:0] i_entry_ready;
    logic                  i_issue_stall;
    logic                  o_pick_valid;
    logic [ENTRY_SIZE-1:0] o_pick_oh;
    logic [ENTRY_W-1:0]    o_pick_index;
    logic [ENTRY_SIZE-1:0] i_issue_succeeded;
    logic [ENTRY_SIZE-1:0] o_clear_entry;
    logic                  i_flush_all;
    logic [ENTRY_W:0]      o_free_count;
    logic                  o_empty;

    // master: dispatch, entries and issue stage together
    modport master (
        output i_put_valid, i_entry_ready, i_issue_stall, i_issue_succeeded, i_flush_all,
        input  o_put_ready, o_put_oh, o_put_index, o_pick_valid, o_pick_oh, o_pick_index,
               o_clear_entry, o_free_count, o_empty
    );

    modport slave (
        input  i_put_valid, i_entry_ready, i_issue_stall, i_issue_succeeded, i_flush_all,
        output o_put_ready, o_put_oh, o_put_index, o_pick_valid, o_pick_oh, o_pick_index,
               o_clear_entry, o_free_count, o_empty
    );

endinterface
`default_nettype wire

// File: rtl/scariv_age_matrix.sv
`default_nettype none
// ============================================================================
//  Module      : scariv_age_matrix
//  Description : Entry age relations and oldest-candidate selection.
//  Revision    : 1.0
// ============================================================================
module scariv_age_matrix
    import scariv_pkg::*;
#(
    parameter int ENTRY_SIZE = ALU_ENTRY_SIZE
) (
    input  wire                  i_clk,
    input  wire                  i_reset,
    input  wire                  i_flush,
    input  wire                  i_put_valid,
    input  wire [ENTRY_SIZE-1:0] i_put_oh,
    input  wire [ENTRY_SIZE-1:0] i_valid,
    input  wire [ENTRY_SIZE-1:0] i_cand,
    output logic [ENTRY_SIZE-1:0] o_oldest_oh
);

    // r_age[i][j] == 1 : entry i is older than entry j
    logic [ENTRY_SIZE-1:0][ENTRY_SIZE-1:0] r_age;

    always_ff @(posedge i_clk) begin
        if (i_reset || i_flush) begin
            r_age <= '0;
        end else if (i_put_valid) begin
            for (int i = 0; i < ENTRY_SIZE; i++) begin
                for (int j = 0; j < ENTRY_SIZE; j++) begin
                    if (i != j) begin
                        if (i_put_oh[i] && i_valid[j]) begin
                            r_age[i][j] <= 1'b0;
                        end else if (i_put_oh[j] && i_valid[i]) begin
                            r_age[i][j] <= 1'b1;
                        end
                    end
                end
            end
        end
    end

    // A candidate wins when no other candidate is older than it.
    for (genvar gi = 0; gi < ENTRY_SIZE; gi++) begin : g_pick
        logic [ENTRY_SIZE-1:0] w_older;
        for (genvar gj = 0; gj < ENTRY_SIZE; gj++) begin : g_col
            assign w_older[gj] = i_cand[gj] & r_age[gj][gi];
        end
        assign o_oldest_oh[gi] = i_cand[gi] & ~(|w_older);
    end

endmodule
`default_nettype wire

// File: rtl/scariv_alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : scariv_alu_issue_ctrl
//  Description : ALU issue queue control: allocation, oldest-ready pick,
//                post-issue clear sequencing and free-entry accounting.
//  Revision    : 1.0
// ============================================================================
module scariv_alu_issue_ctrl
    import scariv_pkg::*;
#(
    parameter int ENTRY_SIZE = ALU_ENTRY_SIZE
) (
    input  wire                        i_clk,
    input  wire                        i_reset,
    scariv_alu_issue_ctrl_if.slave     bus
);

    localparam int ENTRY_W = $clog2(ENTRY_SIZE);
    localparam logic [ENTRY_W:0] c_full_count = (ENTRY_W+1)'(ENTRY_SIZE);

    logic [ENTRY_SIZE-1:0] r_valid;
    logic [ENTRY_SIZE-1:0] r_clear;
    logic [ENTRY_W:0]      r_free_count;

    logic [ENTRY_SIZE-1:0] w_free_vec;
    logic [ENTRY_SIZE-1:0] w_put_oh;
    logic                  w_put_accept;
    logic [ENTRY_SIZE-1:0] w_cand;
    logic [ENTRY_SIZE-1:0] w_oldest_oh;
    logic [ENTRY_SIZE-1:0] w_pick_oh;

    // Releasing entries keep r_valid until their clear pulse ends, so they are never targets.
    assign w_free_vec   = ~r_valid;
    assign w_put_oh     = w_free_vec & (~w_free_vec + ENTRY_SIZE'(1));
    assign w_put_accept = bus.i_put_valid & bus.o_put_ready;

    assign bus.o_put_ready = (r_free_count != '0) & ~bus.i_flush_all;
    assign bus.o_put_oh    = w_put_oh;
    assign bus.o_put_index = ENTRY_W'(onehot_to_index(MAX_ENTRY_SIZE'(w_put_oh)));

    assign w_cand = bus.i_entry_ready & r_valid;

    scariv_age_matrix #(
        .ENTRY_SIZE (ENTRY_SIZE)
    ) u_age_matrix (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_flush     (bus.i_flush_all),
        .i_put_valid (w_put_accept),
        .i_put_oh    (w_put_oh),
        .i_valid     (r_valid),
        .i_cand      (w_cand),
        .o_oldest_oh (w_oldest_oh)
    );

    assign w_pick_oh        = bus.i_issue_stall ? '0 : w_oldest_oh;
    assign bus.o_pick_oh    = w_pick_oh;
    assign bus.o_pick_valid = |w_pick_oh;
    assign bus.o_pick_index = ENTRY_W'(onehot_to_index(MAX_ENTRY_SIZE'(w_pick_oh)));

    assign bus.o_clear_entry = r_clear;
    assign bus.o_free_count  = r_free_count;
    assign bus.o_empty       = (r_free_count == c_full_count);

    always_ff @(posedge i_clk) begin
        if (i_reset || bus.i_flush_all) begin
            r_valid      <= '0;
            r_clear      <= '0;
            r_free_count <= c_full_count;
        end else begin
            r_valid      <= (r_valid & ~r_clear) | (w_put_accept ? w_put_oh : '0);
            // ~r_clear masks a held success so each entry pulses exactly once
            r_clear      <= bus.i_issue_succeeded & r_valid & ~r_clear;
            r_free_count <= r_free_count - {{ENTRY_W{1'b0}}, w_put_accept}
                            + (ENTRY_W+1)'($countones(r_clear));
        end
    end

    a_ready_only_valid: assert property (@(posedge i_clk) disable iff (i_reset)
        (bus.i_entry_ready & ~r_valid) == '0);
    a_pick_onehot0: assert property (@(posedge i_clk) disable iff (i_reset)
        $onehot0(w_pick_oh));
    a_put_onehot0: assert property (@(posedge i_clk) disable iff (i_reset)
        $onehot0(w_put_oh));
    a_free_bound: assert property (@(posedge i_clk) disable iff (i_reset)
        r_free_count <= c_full_count);

endmodule
`default_nettype wire

// File: tb/tb_scariv_alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_scariv_alu_issue_ctrl
//  Description : Directed self-checking bench for scariv_alu_issue_ctrl, 4 entries.
//  Revision    : 1.0
// ============================================================================
module tb_scariv_alu_issue_ctrl;

    localparam int ENTRY_SIZE = 4;

    logic i_clk;
    logic i_reset;
    int   n_tests;
    int   n_fail;

    scariv_alu_issue_ctrl_if #(.ENTRY_SIZE(ENTRY_SIZE)) bus ();

    scariv_alu_issue_ctrl #(
        .ENTRY_SIZE (ENTRY_SIZE)
    ) dut (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .bus     (bus)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        bus.i_put_valid       = 1'b0;
        bus.i_entry_ready     = '0;
        bus.i_issue_stall     = 1'b0;
        bus.i_issue_succeeded = '0;
        bus.i_flush_all       = 1'b0;
        i_reset               = 1'b1;
        tick();
        tick();

        // Reset state
        #4;
        check_eq("rst_free", 32'(bus.o_free_count), 4);
        check_eq("rst_empty", 32'(bus.o_empty), 1);
        check_eq("rst_put_ready", 32'(bus.o_put_ready), 1);
        check_eq("rst_pick_valid", 32'(bus.o_pick_valid), 0);
        check_eq("rst_pick_oh", 32'(bus.o_pick_oh), 0);
        check_eq("rst_clear", 32'(bus.o_clear_entry), 0);
        i_reset = 1'b0;
        tick();

        // 1: fill the queue in index order
        bus.i_put_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #4;
            check_eq("fill_free", 32'(bus.o_free_count), 32'(4 - k));
            if (k < 4) begin
                check_eq("fill_idx", 32'(bus.o_put_index), 32'(k));
                check_eq("fill_oh", 32'(bus.o_put_oh), 32'(1 << k));
                check_eq("fill_ready", 32'(bus.o_put_ready), 1);
            end else begin
                check_eq("full_ready", 32'(bus.o_put_ready), 0);
            end
            tick();
        end
        bus.i_put_valid = 1'b0;

        // 2: oldest pick, then re-put entry 0 as youngest
        bus.i_entry_ready     = 4'b1111;
        bus.i_issue_succeeded = 4'b0001;
        #4;
        check_eq("pick_all_oh", 32'(bus.o_pick_oh), 32'h1);
        check_eq("pick_all_valid", 32'(bus.o_pick_valid), 1);
        check_eq("pick_all_idx", 32'(bus.o_pick_index), 0);
        check_eq("empty_full", 32'(bus.o_empty), 0);
        tick();
        bus.i_issue_succeeded = '0;
        bus.i_entry_ready     = 4'b1110;
        #4;
        check_eq("clr0_pulse", 32'(bus.o_clear_entry), 32'h1);
        check_eq("clr0_free", 32'(bus.o_free_count), 0);
        tick();
        bus.i_put_valid = 1'b1;
        #4;
        check_eq("reput_free", 32'(bus.o_free_count), 1);
        check_eq("reput_idx", 32'(bus.o_put_index), 0);
        check_eq("reput_clr", 32'(bus.o_clear_entry), 0);
        tick();
        bus.i_put_valid   = 1'b0;
        bus.i_entry_ready = 4'b1001;
        #4;
        check_eq("young0_pick", 32'(bus.o_pick_oh), 32'h8);
        check_eq("young0_idx", 32'(bus.o_pick_index), 3);
        check_eq("young0_free", 32'(bus.o_free_count), 0);
        tick();

        // 3: stall gating is combinational
        bus.i_entry_ready = 4'b0010;
        bus.i_issue_stall = 1'b1;
        #4;
        check_eq("stall_valid", 32'(bus.o_pick_valid), 0);
        check_eq("stall_oh", 32'(bus.o_pick_oh), 0);
        bus.i_issue_stall = 1'b0;
        #1;
        check_eq("unstall_oh", 32'(bus.o_pick_oh), 32'h2);
        check_eq("unstall_idx", 32'(bus.o_pick_index), 1);
        tick();
        bus.i_entry_ready = '0;

        // Release entry 3 so that {0,1,2} remain
        bus.i_issue_succeeded = 4'b1000;
        tick();
        bus.i_issue_succeeded = '0;
        #4;
        check_eq("clr3_pulse", 32'(bus.o_clear_entry), 32'h8);
        tick();

        // 4: held success gives a single pulse
        bus.i_issue_succeeded = 4'b0100;
        #4;
        check_eq("hold_t_clr", 32'(bus.o_clear_entry), 0);
        check_eq("hold_t_free", 32'(bus.o_free_count), 1);
        tick();
        #4;
        check_eq("hold_t1_clr", 32'(bus.o_clear_entry), 32'h4);
        check_eq("hold_t1_idx", 32'(bus.o_put_index), 3);
        tick();
        #4;
        check_eq("hold_t2_clr", 32'(bus.o_clear_entry), 0);
        check_eq("hold_t2_free", 32'(bus.o_free_count), 2);
        check_eq("hold_t2_idx", 32'(bus.o_put_index), 2);
        tick();
        bus.i_issue_succeeded = '0;

        // 5: flush on a full queue with a put and a success pending
        bus.i_put_valid = 1'b1;
        tick();
        tick();
        bus.i_put_valid = 1'b0;
        #4;
        check_eq("prefl_free", 32'(bus.o_free_count), 0);
        bus.i_flush_all       = 1'b1;
        bus.i_put_valid       = 1'b1;
        bus.i_issue_succeeded = 4'b0010;
        #1;
        check_eq("flush_put_ready", 32'(bus.o_put_ready), 0);
        tick();
        bus.i_flush_all       = 1'b0;
        bus.i_put_valid       = 1'b0;
        bus.i_issue_succeeded = '0;
        #4;
        check_eq("postfl_free", 32'(bus.o_free_count), 4);
        check_eq("postfl_empty", 32'(bus.o_empty), 1);
        check_eq("postfl_clr", 32'(bus.o_clear_entry), 0);
        check_eq("postfl_idx", 32'(bus.o_put_index), 0);
        tick();
        bus.i_put_valid = 1'b1;
        tick();
        tick();
        tick();
        bus.i_put_valid   = 1'b0;
        bus.i_entry_ready = 4'b0111;
        #4;
        check_eq("postfl_pick", 32'(bus.o_pick_oh), 32'h1);
        check_eq("postfl_free3", 32'(bus.o_free_count), 1);
        bus.i_entry_ready = 4'b0110;
        #1;
        check_eq("postfl_pick2", 32'(bus.o_pick_oh), 32'h2);
        tick();
        bus.i_entry_ready = '0;

        // 6: clear pulse on 1 coincides with an accepted put
        bus.i_issue_succeeded = 4'b0010;
        tick();
        bus.i_issue_succeeded = '0;
        bus.i_put_valid       = 1'b1;
        #4;
        check_eq("co_clr", 32'(bus.o_clear_entry), 32'h2);
        check_eq("co_idx", 32'(bus.o_put_index), 3);
        check_eq("co_ready", 32'(bus.o_put_ready), 1);
        tick();
        #4;
        check_eq("co_free", 32'(bus.o_free_count), 1);
        check_eq("co_idx1", 32'(bus.o_put_index), 1);
        check_eq("co_clr_done", 32'(bus.o_clear_entry), 0);
        tick();
        bus.i_put_valid   = 1'b0;
        bus.i_entry_ready = 4'b1010;
        #4;
        check_eq("co_full", 32'(bus.o_free_count), 0);
        check_eq("co_pick", 32'(bus.o_pick_oh), 32'h8);
        tick();
        bus.i_entry_ready = '0;

        // Reset mid-operation drops a pending clear
        bus.i_issue_succeeded = 4'b0001;
        i_reset               = 1'b1;
        tick();
        bus.i_issue_succeeded = '0;
        i_reset               = 1'b0;
        #4;
        check_eq("midrst_clr", 32'(bus.o_clear_entry), 0);
        check_eq("midrst_free", 32'(bus.o_free_count), 4);
        check_eq("midrst_empty", 32'(bus.o_empty), 1);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
